sfx_mixer: RTL and testbench

SFX_MIXER -- requirements
Module: sfx_mixer

---
 rtl/sfx_mixer_if.sv | 13 +
 rtl/sfx_mixer.sv | 155 +++++++++++++++
 tb/tb_sfx_mixer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfx_mixer_if.sv
// Sample-ROM read port of the sound-effect mixer.
// Handshake: rom_rd is a one-cycle strobe with rom_addr; the ROM returns rom_data in the following cycle; there is no backpressure.
interface sfx_mixer_if #(
  parameter int ADDR_W   = 12,
  parameter int SAMPLE_W = 16
);
  logic                       rom_rd;
  logic [ADDR_W-1:0]          rom_addr;
  logic signed [SAMPLE_W-1:0] rom_data;

  modport master (output rom_rd, output rom_addr, input rom_data);
  modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/sfx_mixer.sv
// Multi-voice sound-effect mixer: once per audio frame, each playing voice fetches one ROM sample,
// and the samples are panned, summed and saturated into a stereo output pair.
module sfx_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int ADDR_W     = 12
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES-1:0]          trigger,
  input  logic [NUM_VOICES-1:0]          stop,
  input  logic [NUM_VOICES-1:0]          loop_en,
  input  logic [NUM_VOICES*ADDR_W-1:0]   voice_base,
  input  logic [NUM_VOICES*ADDR_W-1:0]   voice_len,
  input  logic [NUM_VOICES*2-1:0]        voice_pan,
  sfx_mixer_if.master                    rom,
  output logic signed [SAMPLE_W-1:0]     left_sample,
  output logic signed [SAMPLE_W-1:0]     right_sample,
  output logic [NUM_VOICES-1:0]          busy,
  output logic                           frame_done,
  output logic                           overrun,
  output logic [1:0]                     fsm_state
);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, ACCUM, OUTPUT} state_t;

  state_t                   state, state_nxt;
  logic [VW-1:0]            v;
  logic signed [ACC_W-1:0]  acc_l, acc_r, sample_ext;
  logic [ADDR_W-1:0]        pos [NUM_VOICES];
  logic [NUM_VOICES-1:0]    pend_trig, pend_stop, eff_trig, eff_stop;
  logic [ADDR_W-1:0]        cur_base, cur_len, cur_pos;
  logic [1:0]               cur_pan;
  logic                     cur_busy, cur_loop, fetch_rd;

  function automatic logic signed [SAMPLE_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[SAMPLE_W-1:0];
    else if (a < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
    else                  return a[SAMPLE_W-1:0];
  endfunction

  // Configuration of the voice being serviced is read live, not latched per frame.
  always_comb begin
    cur_base = '0;
    cur_len  = '0;
    cur_pos  = '0;
    cur_pan  = '0;
    cur_busy = 1'b0;
    cur_loop = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (int'(v) == i) begin
        cur_base = voice_base[i*ADDR_W +: ADDR_W];
        cur_len  = voice_len[i*ADDR_W +: ADDR_W];
        cur_pos  = pos[i];
        cur_pan  = voice_pan[i*2 +: 2];
        cur_busy = busy[i];
        cur_loop = loop_en[i];
      end
    end
  end

  // A pulse arriving in the frame-start cycle itself is folded in rather than lost.
  assign eff_trig   = pend_trig | trigger;
  assign eff_stop   = pend_stop | stop;
  assign sample_ext = {{(ACC_W-SAMPLE_W){rom.rom_data[SAMPLE_W-1]}}, rom.rom_data};
  assign fetch_rd   = (state == FETCH) && cur_busy;
  assign rom.rom_rd   = fetch_rd;
  assign rom.rom_addr = fetch_rd ? cur_base + cur_pos : '0;
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = FETCH;
      FETCH:   state_nxt = ACCUM;
      ACCUM:   state_nxt = (v == LAST_V) ? OUTPUT : FETCH;
      OUTPUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v            <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      busy         <= '0;
      pend_trig    <= '0;
      pend_stop    <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) pos[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= sample_tick && (state != IDLE);
      pend_trig  <= pend_trig | trigger;
      pend_stop  <= pend_stop | stop;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            acc_l     <= '0;
            acc_r     <= '0;
            v         <= '0;
            pend_trig <= '0;
            pend_stop <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (eff_stop[i]) begin
                busy[i] <= 1'b0;
              end else if (eff_trig[i] && (voice_len[i*ADDR_W +: ADDR_W] != '0)) begin
                busy[i] <= 1'b1;
                pos[i]  <= '0;
              end
            end
          end
        end
        ACCUM: begin
          if (cur_busy) begin
            if (cur_pan == 2'b00 || cur_pan == 2'b01) acc_l <= acc_l + sample_ext;
            if (cur_pan == 2'b00 || cur_pan == 2'b10) acc_r <= acc_r + sample_ext;
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (int'(v) == i) begin
                if (pos[i] == cur_len - 1'b1) begin
                  pos[i]  <= '0;
                  busy[i] <= cur_loop;
                end else begin
                  pos[i] <= pos[i] + 1'b1;
                end
              end
            end
          end
          if (v != LAST_V) v <= v + 1'b1;
        end
        OUTPUT: begin
          left_sample  <= sat(acc_l);
          right_sample <= sat(acc_r);
          frame_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sfx_mixer.sv
// Self-checking bench for sfx_mixer: reset, table-driven mix/saturation vectors, event corner cases
// and randomized frames against a frame-level reference model.
module tb_sfx_mixer;
  localparam int NV = 4;
  localparam int AW = 12;
  localparam int SW = 16;

  logic              clk;
  logic              reset_n;
  logic              sample_tick;
  logic [NV-1:0]     trigger, stop, loop_en;
  logic [NV*AW-1:0]  voice_base, voice_len;
  logic [NV*2-1:0]   voice_pan;
  logic [SW-1:0]     left_sample, right_sample;
  logic [NV-1:0]     busy;
  logic              frame_done, overrun;
  logic [1:0]        fsm_state;

  sfx_mixer_if #(.ADDR_W(AW), .SAMPLE_W(SW)) rom_bus ();

  sfx_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
    .trigger(trigger), .stop(stop), .loop_en(loop_en),
    .voice_base(voice_base), .voice_len(voice_len), .voice_pan(voice_pan),
    .rom(rom_bus),
    .left_sample(left_sample), .right_sample(right_sample),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model and read-address log
  logic signed [SW-1:0] mem [4096];
  logic [AW-1:0]        rd_q[$];
  always @(posedge clk) begin
    rom_bus.rom_data <= rom_bus.rom_rd ? mem[rom_bus.rom_addr] : 16'h5A5A;
    if (rom_bus.rom_rd) rd_q.push_back(rom_bus.rom_addr);
  end

  // scoreboard state
  int            checks = 0;
  int            failures = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [SW-1:0] exp_l, exp_r;
  logic [NV-1:0] m_busy, m_ptrig, m_pstop;
  int            m_pos [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] clamp(input int x);
    logic [31:0] t;
    if (x > 32767)  return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    t = x;
    return t[SW-1:0];
  endfunction

  task automatic model_reset();
    m_busy = '0; m_ptrig = '0; m_pstop = '0;
    for (int i = 0; i < NV; i++) m_pos[i] = 0;
  endtask

  // One frame of the mixer expressed directly as arithmetic over the voices.
  task automatic model_frame();
    int sl, sr, s, a, ln, b;
    logic [1:0] p;
    for (int i = 0; i < NV; i++) begin
      ln = int'(voice_len[i*AW +: AW]);
      if (m_pstop[i]) m_busy[i] = 1'b0;
      else if (m_ptrig[i] && ln != 0) begin m_busy[i] = 1'b1; m_pos[i] = 0; end
    end
    m_ptrig = '0; m_pstop = '0;
    sl = 0; sr = 0;
    exp_addr_q.delete();
    for (int i = 0; i < NV; i++) begin
      if (m_busy[i]) begin
        b  = int'(voice_base[i*AW +: AW]);
        ln = int'(voice_len[i*AW +: AW]);
        p  = voice_pan[i*2 +: 2];
        a  = (b + m_pos[i]) % 4096;
        exp_addr_q.push_back(12'(a));
        s = int'(mem[a]);
        if (p == 2'b00 || p == 2'b01) sl += s;
        if (p == 2'b00 || p == 2'b10) sr += s;
        if (m_pos[i] == (ln + 4095) % 4096) begin m_pos[i] = 0; m_busy[i] = loop_en[i]; end
        else m_pos[i] = (m_pos[i] + 1) % 4096;
      end
    end
    exp_l = clamp(sl);
    exp_r = clamp(sr);
  endtask

  // driver tasks
  task automatic set_voice(input int v, input logic [AW-1:0] b, input logic [AW-1:0] l,
                           input logic [1:0] p, input logic lp);
    voice_base[v*AW +: AW] = b;
    voice_len[v*AW +: AW]  = l;
    voice_pan[v*2 +: 2]    = p;
    loop_en[v]             = lp;
  endtask

  task automatic pulse(input logic [NV-1:0] t, input logic [NV-1:0] s);
    @(negedge clk);
    trigger = t; stop = s;
    m_ptrig |= t; m_pstop |= s;
    @(negedge clk);
    trigger = '0; stop = '0;
  endtask

  // mid_kind: 0 none, 1 extra tick at cycle mid_cyc, 2 trigger mid_mask at cycle mid_cyc
  task automatic run_frame(input int mid_kind, input int mid_cyc, input logic [NV-1:0] mid_mask);
    int lat;
    int n;
    model_frame();
    rd_q.delete();
    @(negedge clk);
    sample_tick = 1'b1;
    lat = 0;
    for (int j = 1; j <= 3*NV && lat == 0; j++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      trigger = '0;
      if (frame_done) lat = j;
      if (mid_kind == 1 && j == mid_cyc + 1) check("overrun_pulse", 32'(overrun), 32'd1);
      if (mid_kind == 1 && j == mid_cyc) sample_tick = 1'b1;
      if (mid_kind == 2 && j == mid_cyc) begin trigger = mid_mask; m_ptrig |= mid_mask; end
    end
    if (trigger != '0) begin @(negedge clk); trigger = '0; end
    check("frame_latency", 32'(lat), 32'(2*NV+2));
    check("left_sample", 32'(left_sample), 32'(exp_l));
    check("right_sample", 32'(right_sample), 32'(exp_r));
    check("busy", 32'(busy), 32'(m_busy));
    if (mid_kind != 1) check("overrun_quiet", 32'(overrun), 32'd0);
    check("rom_read_count", 32'(rd_q.size()), 32'(exp_addr_q.size()));
    n = (rd_q.size() < exp_addr_q.size()) ? rd_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) check("rom_addr", 32'(rd_q[i]), 32'(exp_addr_q[i]));
  endtask

  typedef struct {
    logic [63:0]   vals;  // voice3..voice0 ROM sample
    logic [7:0]    pan;   // voice3..voice0 pan code
    logic [SW-1:0] el;
    logic [SW-1:0] er;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NV-1:0] rt, rs, rm;
    logic [AW-1:0] rb, rl;
    logic [1:0]    rp;
    logic          rlp;
    bit            fd_seen;

    vecs[0] = '{64'h0004_001E_00C8_03E8, 8'h00, 16'd1234, 16'd1234};
    vecs[1] = '{64'h7000_7000_7000_7000, 8'h00, 16'h7FFF, 16'h7FFF};
    vecs[2] = '{64'h9000_9000_9000_9000, 8'h00, 16'h8000, 16'h8000};
    vecs[3] = '{64'h0007_0032_FED4_0064, 8'h39, 16'h006B, 16'hFEDB};
    vecs[4] = '{64'h0000_FFFF_0001_7FFF, 8'h00, 16'h7FFF, 16'h7FFF};
    vecs[5] = '{64'h7FFF_7FFF_8000_8000, 8'h00, 16'hFFFE, 16'hFFFE};
    vecs[6] = '{64'h0000_0320_3E80_3E80, 8'hD5, 16'h7FFF, 16'h0000};

    reset_n = 1'b0; sample_tick = 1'b0; trigger = '0; stop = '0; loop_en = '0;
    voice_base = '0; voice_len = '0; voice_pan = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'sh0111;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_left", 32'(left_sample), 32'd0);
    check("reset_right", 32'(right_sample), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rom_rd", 32'(rom_bus.rom_rd), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;

    // idle frames: no reads, silent output
    for (int f = 0; f < 3; f++) run_frame(0, 0, '0);

    // table-driven single-frame mixing and saturation
    for (int k = 0; k < 7; k++) begin
      for (int v = 0; v < NV; v++) begin
        set_voice(v, 12'(12'h800 + v*12'h100), 12'd1, vecs[k].pan[v*2 +: 2], 1'b0);
        mem[12'h800 + v*12'h100] = vecs[k].vals[v*16 +: 16];
      end
      pulse(4'hF, 4'h0);
      run_frame(0, 0, '0);
      check("vec_left", 32'(left_sample), 32'(vecs[k].el));
      check("vec_right", 32'(right_sample), 32'(vecs[k].er));
    end

    // one-shot voice 0
    set_voice(0, 12'h100, 12'd3, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) mem[12'h100 + i] = 16'sd1000;
    pulse(4'b0001, 4'b0000);
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 0, '0);
      check("oneshot_left", 32'(left_sample), 32'd1000);
      check("oneshot_right", 32'(right_sample), 32'd1000);
    end
    run_frame(0, 0, '0);
    check("oneshot_end_busy", 32'(busy[0]), 32'd0);
    check("oneshot_end_left", 32'(left_sample), 32'd0);

    // pan and loop: voice1 left looping, voice2 right one-shot
    set_voice(1, 12'h200, 12'd2, 2'b01, 1'b1);
    set_voice(2, 12'h300, 12'd4, 2'b10, 1'b0);
    mem[12'h200] = 16'sh0123; mem[12'h201] = 16'sh0456;
    for (int i = 0; i < 4; i++) mem[12'h300 + i] = 16'(16'h0010 * (i + 1));
    pulse(4'b0110, 4'b0000);
    run_frame(0, 0, '0);
    check("pan_left_first", 32'(left_sample), 32'h0123);
    check("pan_right_first", 32'(right_sample), 32'h0010);
    for (int f = 0; f < 4; f++) run_frame(0, 0, '0);

    // events: trigger+stop together, zero length, mid-frame trigger
    set_voice(3, 12'h3F0, 12'd2, 2'b00, 1'b0);
    pulse(4'b1000, 4'b1000);
    run_frame(0, 0, '0);
    check("trig_stop_busy3", 32'(busy[3]), 32'd0);
    set_voice(0, 12'h100, 12'd0, 2'b00, 1'b0);
    pulse(4'b0001, 4'b0000);
    run_frame(0, 0, '0);
    check("len0_busy0", 32'(busy[0]), 32'd0);
    set_voice(0, 12'h040, 12'd2, 2'b00, 1'b0);
    mem[12'h040] = 16'sd5; mem[12'h041] = 16'sd6;
    run_frame(2, 5, 4'b0001);
    check("midtrig_not_yet", 32'(busy[0]), 32'd0);
    run_frame(0, 0, '0);
    check("midtrig_next_frame", 32'(busy[0]), 32'd1);

    // tick during FETCH of voice 1
    run_frame(1, 3, '0);

    // reset in the middle of ACCUM
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_left", 32'(left_sample), 32'd0);
    check("rst_right", 32'(right_sample), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rom_rd", 32'(rom_bus.rom_rd), 32'd0);
    check("rst_rom_addr", 32'(rom_bus.rom_addr), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fd_seen = 1'b0;
    repeat (15) begin @(negedge clk); if (frame_done) fd_seen = 1'b1; end
    check("no_done_after_abort", 32'(fd_seen), 32'd0);
    pulse(4'b0010, 4'b0000);
    run_frame(0, 0, '0);

    // randomized frames
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom_range(0, 65535));
    for (int f = 0; f < 40; f++) begin
      for (int v = 0; v < NV; v++) begin
        if ($urandom_range(0, 3) == 0) begin
          rb = 12'($urandom_range(0, 4095));
          rl = 12'($urandom_range(0, 5));
          rp = 2'($urandom_range(0, 3));
          rlp = 1'($urandom_range(0, 1));
          set_voice(v, rb, rl, rp, rlp);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        rt = 4'($urandom_range(0, 15));
        rs = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        pulse(rt, rs);
      end
      if ($urandom_range(0, 3) == 0) begin
        rm = 4'($urandom_range(0, 15));
        run_frame(2, int'($urandom_range(1, 9)), rm);
      end else begin
        run_frame(0, 0, '0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
